// File: rtl/uart_rx_if.sv
// Host-side signal bundle of the UART receiver: serial line, frame format,
// acknowledge, received byte and status flags.
interface uart_rx_if;
    logic       DATA_IN_Rx;
    logic       UART_BITS;
    logic       UART_PARITY;
    logic       UART_READ;
    logic [7:0] DATA_OUT_Rx;
    logic       IRQ_Rx;
    logic       PARITY_ERR;
    logic       FRAME_ERR;
    logic       OVERRUN_ERR;

    // Host / line driver side
    modport master (
        output DATA_IN_Rx, UART_BITS, UART_PARITY, UART_READ,
        input  DATA_OUT_Rx, IRQ_Rx, PARITY_ERR, FRAME_ERR, OVERRUN_ERR
    );

    // Receiver side
    modport slave (
        input  DATA_IN_Rx, UART_BITS, UART_PARITY, UART_READ,
        output DATA_OUT_Rx, IRQ_Rx, PARITY_ERR, FRAME_ERR, OVERRUN_ERR
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, detects and validates the
// start bit, samples 7/8 data bits (plus optional parity and one stop bit)
// in the middle of each bit period and publishes the byte with a sticky
// completion flag and parity / framing / overrun status.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2,
    parameter int PARITY_ODD   = 0
) (
    input  logic     clk,
    input  logic     RST,
    uart_rx_if.slave bus_if
);

    // Bit-period counter wide enough for CLKS_PER_BIT-1 (at least one bit).
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // Offset of the sampling point inside a bit period.
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic          ODD_PAR  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // Line synchroniser; the newest sample enters at bit 0, s is the top bit.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            bits8_q, bits8_d;
    logic            par_en_q, par_en_d;
    logic            perr_int_q, perr_int_d;

    logic [7:0]      dout_q, dout_d;
    logic            irq_q, irq_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;

    logic            bit_tick;
    logic [2:0]      last_bit;

    assign s        = sync_q[SYNC_STAGES-1];
    assign bit_tick = (cnt_q == CNT_LAST);
    assign last_bit = bits8_q ? 3'd7 : 3'd6;

    // Shift the raw line through the synchroniser; idle level after reset.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus_if.DATA_IN_Rx};
        end
    end

    // State and datapath registers; a reset mid-frame simply abandons it.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            bits8_q    <= 1'b0;
            par_en_q   <= 1'b0;
            perr_int_q <= 1'b0;
            dout_q     <= '0;
            irq_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            bits8_q    <= bits8_d;
            par_en_q   <= par_en_d;
            perr_int_q <= perr_int_d;
            dout_q     <= dout_d;
            irq_q      <= irq_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next-state, bit sampling and host-visible status updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        bits8_d    = bits8_q;
        par_en_d   = par_en_q;
        perr_int_d = perr_int_q;
        dout_d     = dout_q;
        irq_d      = irq_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;

        // Acknowledge consumes the pending byte; completion below overrides.
        if (bus_if.UART_READ) begin
            irq_d = 1'b0;
            ovr_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!s) begin
                    // Frame format is frozen here for the whole frame.
                    bit_d      = '0;
                    shreg_d    = '0;
                    perr_int_d = 1'b0;
                    bits8_d    = bus_if.UART_BITS;
                    par_en_d   = bus_if.UART_PARITY;
                    if (HALF == 0) begin
                        // Mid-start check coincides with detection itself.
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_START;
                        cnt_d   = CW'(1);
                    end
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (s) begin
                        state_d = S_IDLE;   // glitch shorter than half a bit
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (bit_tick) begin
                    cnt_d          = '0;
                    shreg_d[bit_q] = s;
                    if (bit_q == last_bit) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_PARITY: begin
                if (bit_tick) begin
                    cnt_d      = '0;
                    // Unused bit 7 is zero in 7-bit mode, so it drops out.
                    perr_int_d = s ^ (^shreg_q) ^ ODD_PAR;
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_STOP: begin
                if (bit_tick) begin
                    cnt_d  = '0;
                    dout_d = bits8_q ? shreg_q : {1'b0, shreg_q[6:0]};
                    perr_d = par_en_q & perr_int_q;
                    ferr_d = ~s;
                    irq_d  = 1'b1;
                    // A simultaneous read took the old byte: no overrun.
                    ovr_d  = irq_q & ~bus_if.UART_READ;
                    state_d = s ? S_IDLE : S_BREAK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_BREAK: begin
                // Held-low line: wait for it to return high before rearming.
                if (s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus_if.DATA_OUT_Rx = dout_q;
    assign bus_if.IRQ_Rx      = irq_q;
    assign bus_if.PARITY_ERR  = perr_q;
    assign bus_if.FRAME_ERR   = ferr_q;
    assign bus_if.OVERRUN_ERR = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (1 clk/bit even parity, 16 clk/bit odd
// parity, 1 clk/bit odd parity with a 3-stage synchroniser) driven by
// directed and random frames, compared against a frame-level model.
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n [3];
    logic pin   [3];
    logic bits_v[3];
    logic par_v [3];
    logic rd    [3];

    logic [7:0] dout_w[3];
    logic       irq_w [3];
    logic       perr_w[3];
    logic       ferr_w[3];
    logic       ovr_w [3];

    // Frame-level model of what the host should see per receiver.
    logic [7:0] m_dout[3];
    logic       m_irq [3];
    logic       m_perr[3];
    logic       m_ferr[3];
    logic       m_ovr [3];

    int checks = 0;
    int errors = 0;

    uart_rx_if if_a ();
    uart_rx_if if_b ();
    uart_rx_if if_c ();

    assign if_a.DATA_IN_Rx  = pin[0];
    assign if_a.UART_BITS   = bits_v[0];
    assign if_a.UART_PARITY = par_v[0];
    assign if_a.UART_READ   = rd[0];
    assign if_b.DATA_IN_Rx  = pin[1];
    assign if_b.UART_BITS   = bits_v[1];
    assign if_b.UART_PARITY = par_v[1];
    assign if_b.UART_READ   = rd[1];
    assign if_c.DATA_IN_Rx  = pin[2];
    assign if_c.UART_BITS   = bits_v[2];
    assign if_c.UART_PARITY = par_v[2];
    assign if_c.UART_READ   = rd[2];

    assign dout_w[0] = if_a.DATA_OUT_Rx;
    assign irq_w[0]  = if_a.IRQ_Rx;
    assign perr_w[0] = if_a.PARITY_ERR;
    assign ferr_w[0] = if_a.FRAME_ERR;
    assign ovr_w[0]  = if_a.OVERRUN_ERR;
    assign dout_w[1] = if_b.DATA_OUT_Rx;
    assign irq_w[1]  = if_b.IRQ_Rx;
    assign perr_w[1] = if_b.PARITY_ERR;
    assign ferr_w[1] = if_b.FRAME_ERR;
    assign ovr_w[1]  = if_b.OVERRUN_ERR;
    assign dout_w[2] = if_c.DATA_OUT_Rx;
    assign irq_w[2]  = if_c.IRQ_Rx;
    assign perr_w[2] = if_c.PARITY_ERR;
    assign ferr_w[2] = if_c.FRAME_ERR;
    assign ovr_w[2]  = if_c.OVERRUN_ERR;

    uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2), .PARITY_ODD(0)) u_a (
        .clk(clk), .RST(rst_n[0]), .bus_if(if_a));
    uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2), .PARITY_ODD(1)) u_b (
        .clk(clk), .RST(rst_n[1]), .bus_if(if_b));
    uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(3), .PARITY_ODD(1)) u_c (
        .clk(clk), .RST(rst_n[2]), .bus_if(if_c));

    function automatic int cpb_of(input int idx);
        return (idx == 1) ? 16 : 1;
    endfunction

    function automatic logic odd_of(input int idx);
        return (idx != 0);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int idx, input string tag);
        chk($sformatf("%s_u%0d_dout", tag, idx), dout_w[idx], m_dout[idx]);
        chk($sformatf("%s_u%0d_irq", tag, idx), {7'd0, irq_w[idx]}, {7'd0, m_irq[idx]});
        chk($sformatf("%s_u%0d_perr", tag, idx), {7'd0, perr_w[idx]}, {7'd0, m_perr[idx]});
        chk($sformatf("%s_u%0d_ferr", tag, idx), {7'd0, ferr_w[idx]}, {7'd0, m_ferr[idx]});
        chk($sformatf("%s_u%0d_ovr", tag, idx), {7'd0, ovr_w[idx]}, {7'd0, m_ovr[idx]});
        $display("frame %s u%0d: dout=%02h irq=%0b perr=%0b ferr=%0b ovr=%0b",
                 tag, idx, dout_w[idx], irq_w[idx], perr_w[idx], ferr_w[idx], ovr_w[idx]);
    endtask

    task automatic model_reset(input int idx);
        m_dout[idx] = 8'h00;
        m_irq[idx]  = 1'b0;
        m_perr[idx] = 1'b0;
        m_ferr[idx] = 1'b0;
        m_ovr[idx]  = 1'b0;
    endtask

    // Drive one frame starting at a falling edge. In narrow mode each
    // non-start bit carries its true level only from the mid-bit cycle
    // (stop bit: from mid-bit on) and the inverted level elsewhere, so only
    // sampling at exactly that cycle recovers the byte.
    task automatic send(input int idx, input logic [7:0] data, input logic nb8,
                        input logic p, input logic flip, input logic stop,
                        input logic narrow);
        logic [11:0] seq;
        logic [7:0]  d;
        int          n;
        int          cpb;
        int          half;
        d    = nb8 ? data : {1'b0, data[6:0]};
        cpb  = cpb_of(idx);
        half = (cpb - 1) / 2;
        seq  = '0;
        n    = 0;
        seq[n] = 1'b0;
        n++;
        for (int i = 0; i < (nb8 ? 8 : 7); i++) begin
            seq[n] = data[i];
            n++;
        end
        if (p) begin
            seq[n] = (^d) ^ odd_of(idx) ^ flip;
            n++;
        end
        seq[n] = stop;
        n++;
        bits_v[idx] = nb8;
        par_v[idx]  = p;
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < cpb; j++) begin
                if (!narrow || b == 0 || j == half || (b == n - 1 && j > half))
                    pin[idx] = seq[b];
                else
                    pin[idx] = ~seq[b];
                // Format inputs change mid-frame; the receiver must ignore it.
                if (b == 5 && j == 0) begin
                    bits_v[idx] = 1'($urandom);
                    par_v[idx]  = 1'($urandom);
                end
                @(negedge clk);
            end
        end
        m_dout[idx] = d;
        m_perr[idx] = p & flip;
        m_ferr[idx] = ~stop;
        m_ovr[idx]  = m_irq[idx];
        m_irq[idx]  = 1'b1;
    endtask

    task automatic pulse_read(input int idx, input string tag);
        rd[idx] = 1'b1;
        @(negedge clk);
        rd[idx] = 1'b0;
        m_irq[idx] = 1'b0;
        m_ovr[idx] = 1'b0;
        check_all(idx, tag);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int          idx;
        logic [7:0]  rdata;
        logic        rnb8, rp, rflip, rstop, rnarrow;

        for (int i = 0; i < 3; i++) begin
            rst_n[i]  = 1'b0;
            pin[i]    = 1'b1;
            bits_v[i] = 1'b1;
            par_v[i]  = 1'b0;
            rd[i]     = 1'b0;
            model_reset(i);
        end
        idle(3);
        for (int i = 0; i < 3; i++) check_all(i, "reset");
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        idle(4);

        // 0xA5, 8N1 at 1 clk/bit: completion flag exactly at t0+10.
        send(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("a5_irq_t0p9", {7'd0, irq_w[0]}, 8'd0);
        @(negedge clk);
        chk("a5_irq_t0p10", {7'd0, irq_w[0]}, 8'd1);
        idle(2);
        check_all(0, "a5");
        pulse_read(0, "a5_read");

        // 7-bit 0x55 with even parity: good then bad parity bit.
        send(0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_all(0, "p55_good");
        pulse_read(0, "p55_good_read");
        send(0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);
        check_all(0, "p55_bad");
        pulse_read(0, "p55_bad_read");

        // Odd-parity receiver: parity bit 1 on 0x55 is correct.
        send(2, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_all(2, "p55_odd");
        pulse_read(2, "p55_odd_read");

        // Missing stop bit, line held low: one framing-error frame only.
        send(0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        check_all(0, "brk3c_low");
        pin[0] = 1'b1;
        idle(4);
        check_all(0, "brk3c_high");
        pulse_read(0, "brk3c_read");
        send(0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_all(0, "after_brk_81");
        pulse_read(0, "after_brk_read");

        // Back-to-back frames without an acknowledge overrun.
        send(0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send(0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_all(0, "b2b_22");
        pulse_read(0, "b2b_read");

        // Acknowledge on the exact completion edge: flag stays, no overrun.
        send(0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_all(0, "pre_33");
        send(0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rd[0] = 1'b1;
        @(negedge clk);
        rd[0] = 1'b0;
        m_ovr[0] = 1'b0;
        check_all(0, "rd_on_edge_44");
        idle(4);
        check_all(0, "rd_on_edge_44_late");
        pulse_read(0, "rd_on_edge_read");

        // 16 clk/bit: a 5-cycle glitch is rejected as a false start.
        pin[1] = 1'b0;
        idle(5);
        pin[1] = 1'b1;
        idle(40);
        check_all(1, "glitch");
        // 0xC3 readable only when each bit is taken at its mid-bit cycle.
        send(1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4);
        check_all(1, "c3_narrow");

        // Reset in the middle of data bit 4, then a clean 0x7E frame.
        pin[1] = 1'b0;
        idle(16);
        rdata = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            pin[1] = rdata[i];
            idle(16);
        end
        pin[1] = rdata[4];
        idle(8);
        rst_n[1] = 1'b0;
        pin[1]   = 1'b1;
        model_reset(1);
        #1;
        check_all(1, "async_rst");
        idle(3);
        rst_n[1] = 1'b1;
        idle(60);
        check_all(1, "post_rst_idle");
        send(1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_all(1, "post_rst_7e");
        pulse_read(1, "post_rst_read");

        // Random frames on all three receivers.
        for (int r = 0; r < 45; r++) begin
            idx     = r % 3;
            rdata   = 8'($urandom);
            rnb8    = 1'($urandom);
            rp      = 1'($urandom);
            rflip   = 1'($urandom);
            rstop   = ($urandom_range(0, 7) != 0);
            rnarrow = (idx == 1);
            send(idx, rdata, rnb8, rp, rflip, rstop, rnarrow);
            if (!rstop) begin
                idle($urandom_range(1, 20));
                pin[idx] = 1'b1;
            end
            idle(4);
            check_all(idx, $sformatf("rnd%0d", r));
            if ($urandom_range(0, 1) == 1) pulse_read(idx, $sformatf("rnd%0d_read", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that pairs with the team's UART transmitter.
- Deserialises an asynchronous frame: start bit (0), 7 or 8 data bits LSB-first, optional parity bit, one stop bit (1).
- Presents the received byte with a completion interrupt held until the host acknowledges it.
- Reports parity, framing and overrun errors; supports oversampled mid-bit sampling for a faster local clock.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit (>=1); 1 matches the transmitter's one-bit-per-clock timing.
- SYNC_STAGES, 2, flip-flop stages on DATA_IN_Rx before use (>=2).
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd.

Ports:
- clk  input  1  system clock
- RST  input  1  reset; asynchronous, active-low
- DATA_IN_Rx  input  1  serial line, idle high
- UART_BITS  input  1  1 = 8 data bits, 0 = 7 data bits
- UART_PARITY  input  1  1 = parity bit present after data
- UART_READ  input  1  host acknowledge; clears IRQ_Rx and OVERRUN_ERR
- DATA_OUT_Rx  output  8  last received data; bit 7 forced 0 in 7-bit mode
- IRQ_Rx  output  1  frame-complete flag, held until UART_READ
- PARITY_ERR  output  1  parity mismatch on last completed frame
- FRAME_ERR  output  1  stop bit sampled 0 on last completed frame
- OVERRUN_ERR  output  1  frame completed while IRQ_Rx already set

Behaviour:
- Reset (async, RST=0): state IDLE; synchroniser flops 1; counters 0; DATA_OUT_Rx=8'h00; IRQ_Rx, PARITY_ERR, FRAME_ERR, OVERRUN_ERR = 0. Reset mid-frame abandons the frame; no outputs update.
- Sample s = synchroniser output, SYNC_STAGES cycles behind the pin. All timing below is in s-cycles.
- HALF = (CLKS_PER_BIT-1)/2 (integer). nb = 8 if UART_BITS else 7. p = UART_PARITY.
- UART_BITS and UART_PARITY are latched at start detection. Changes mid-frame are ignored.
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: first cycle t0 with s=0 begins a frame and enters START. Bit counter is cleared.
- START: at t0+HALF, re-check s.
  - s=1: false start, return to IDLE with no output change.
  - s=0: enter DATA.
  - When HALF=0 the check occurs in cycle t0 itself.
- DATA: bit i (0..nb-1) sampled at t0+HALF+CLKS_PER_BIT*(i+1) into shift register position i. After bit nb-1, go to PARITY if p, else STOP.
- PARITY: sampled at t0+HALF+CLKS_PER_BIT*(nb+1).
  - Expected value = XOR of the nb data bits, XOR PARITY_ODD.
  - Mismatch sets the internal perr.
- STOP: sampled at t0+HALF+CLKS_PER_BIT*(nb+1+p). On the edge ending the stop-sample cycle:
  - DATA_OUT_Rx <= received bits, zero-extended for 7-bit frames.
  - PARITY_ERR <= perr (0 if p=0).
  - FRAME_ERR <= (stop sample==0).
  - IRQ_Rx <= 1.
  - OVERRUN_ERR <= 1 if IRQ_Rx was already 1 (data is overwritten).
  - Next state: IDLE if stop=1, BREAK if stop=0.
- BREAK: remain until s=1 for one cycle, then IDLE. A held-low line produces exactly one FRAME_ERR frame.
- With CLKS_PER_BIT=1, a new start bit may be detected in the cycle immediately after the stop sample. Back-to-back frames have no idle gap.
- UART_READ=1 on an edge with no completion: IRQ_Rx <= 0, OVERRUN_ERR <= 0. DATA_OUT_Rx and error flags are held.
- UART_READ and completion on the same edge: completion wins. IRQ_Rx stays 1, OVERRUN_ERR <= 0 (the read consumed the previous byte).
- Error flags PARITY_ERR and FRAME_ERR change only at frame completion or reset.

Test Plan:
- CLKS_PER_BIT=1, 8-bit, no parity; pin drives 0,1,0,1,0,0,1,0,1,1 (0xA5 then stop) -> DATA_OUT_Rx=8'hA5, IRQ_Rx=1 at s-cycle t0+10, all error flags 0; UART_READ pulse -> IRQ_Rx=0.
- 7-bit, even parity, data 0x55 (four ones): parity bit 0 -> DATA_OUT_Rx=8'h55, PARITY_ERR=0. Repeat with parity bit 1 -> PARITY_ERR=1, data still 8'h55. Repeat with PARITY_ODD=1 and parity bit 1 -> PARITY_ERR=0.
- Frame 0x3C with stop bit 0, line held low 20 cycles -> FRAME_ERR=1, IRQ_Rx=1, no further frame until line high. Next valid 0x81 -> DATA_OUT_Rx=8'h81, FRAME_ERR=0.
- Two back-to-back frames 0x11 then 0x22, no UART_READ -> DATA_OUT_Rx=8'h22, OVERRUN_ERR=1. Then UART_READ -> IRQ_Rx=0, OVERRUN_ERR=0. Also test UART_READ asserted on the exact completion edge of a frame -> IRQ_Rx=1, OVERRUN_ERR=0.
- CLKS_PER_BIT=16 (HALF=7): 5-cycle low glitch -> no frame, state back to IDLE. Full 0xC3 frame at 16 clk/bit -> correct byte, each bit sampled at cycle 7 of its bit period.
- Assert RST during DATA bit 4 of a frame -> all outputs 0 immediately. After release, the remainder of the aborted frame is ignored (line high => IDLE) and the next full frame 0x7E is received correctly.
